// File: rtl/ram_burst_master.sv
// Burst initiator for a registered-read single-port RAM: command-driven write and read bursts,
// with a 2-entry read FIFO so read data survives arbitrary rd_ready backpressure.
module ram_burst_master #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] beats_left_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              done_q;
    logic              inflight_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic       in_burst;
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ;
    logic [1:0] fifo_cnt_d;

    assign in_burst   = (state_q == StWrite) || (state_q == StRead);
    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign wr_ready   = (state_q == StWrite);
    assign done       = done_q;

    assign mem_we     = (state_q == StWrite) && wr_valid;
    assign mem_data   = (state_q == StWrite) ? wr_data : '0;
    assign mem_addr   = in_burst ? cur_addr_q : addr_hold_q;

    assign rd_valid   = (fifo_cnt_q != 2'd0);
    assign rd_data    = rd_valid ? fifo_q[rd_ptr_q] : '0;

    // A read issued last cycle lands on mem_q now and is pushed at this edge.
    assign push       = inflight_q;
    assign pop        = rd_valid && rd_ready;
    assign occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    // Never let buffered plus in-flight reads exceed the two FIFO slots.
    assign issue      = (state_q == StRead) && (occ < (3'd2 + {2'b00, pop}));
    assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            addr_hold_q  <= '0;
            done_q       <= 1'b0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fifo_cnt_q   <= 2'd0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (in_burst) begin
                addr_hold_q <= cur_addr_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cur_addr_q   <= cmd_addr;
                        beats_left_q <= cmd_len;
                        state_q      <= cmd_write ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (wr_valid) begin
                        cur_addr_q   <= cur_addr_q + AddrOne;
                        beats_left_q <= beats_left_q - AddrOne;
                        if (beats_left_q == '0) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (issue) begin
                        cur_addr_q   <= cur_addr_q + AddrOne;
                        beats_left_q <= beats_left_q - AddrOne;
                        if (beats_left_q == '0) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!inflight_q && (fifo_cnt_d == 2'd0)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Burst initiator that drives the synchronous single-port RAM (8-bit data, 6-bit address, registered read) from a command/stream interface. It accepts one burst command at a time, then streams write data into consecutive RAM locations or streams read data out under valid/ready flow control. It sits between a datapath client and `single_port_ram`, and owns the RAM's `data`/`addr`/`we` pins.

## Interface
Parameters:
- `DATA_W`, 8, RAM word width
- `ADDR_W`, 6, RAM address width; also the width of the burst-length field

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid && cmd_ready`
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  ADDR_W  beats minus 1 (0 → 1 beat, 63 → 64 beats)
- `wr_valid`  in  1  write beat offered
- `wr_ready`  out  1  write beat accepted on `wr_valid && wr_ready`
- `wr_data`  in  DATA_W  write beat data
- `rd_valid`  out  1  read beat available
- `rd_ready`  in  1  read beat consumed on `rd_valid && rd_ready`
- `rd_data`  out  DATA_W  read beat data
- `mem_addr`  out  ADDR_W  to RAM `addr`
- `mem_data`  out  DATA_W  to RAM `data`
- `mem_we`  out  1  to RAM write enable
- `mem_q`  in  DATA_W  from RAM `q`, valid the cycle after `mem_addr` is presented
- `busy`  out  1  high whenever the block is not in IDLE
- `done`  out  1  one-cycle pulse, burst complete

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: `cmd_ready=1`. On accept, latch `cur_addr=cmd_addr` and `beats_left=cmd_len`, then go to WRITE or READ according to `cmd_write`.
- WRITE: `wr_ready=1`. Drive `mem_we = wr_valid`, `mem_data = wr_data` and `mem_addr = cur_addr`, all combinationally. On each beat, `cur_addr` increments modulo 2^ADDR_W (0x3F wraps to 0x00). After the beat with `beats_left==0`, go to IDLE and pulse `done`.
- READ: 2-entry output FIFO. Issue a read (`mem_addr = cur_addr`, `mem_we = 0`) when `fifo_count + inflight - pop < 2`, where `pop = rd_valid && rd_ready`.
- Read pipeline: an issued read returns on `mem_q` the next cycle and is pushed into the FIFO at that edge. `cur_addr` increments per issue. After issuing the last beat, go to DRAIN.
- DRAIN: no issues. Go to IDLE when `inflight==0`, the FIFO is empty and the final pop completes; pulse `done` on that transition.
- `rd_valid` = FIFO non-empty. `rd_data` = FIFO head. Read data is strictly in address order, with no loss or duplication under any `rd_ready` pattern.
- Outside WRITE: `mem_we=0` and `mem_data=0`. Outside READ/WRITE: `mem_addr` holds its last value. `wr_ready=0` outside WRITE.
- `cmd_valid` outside IDLE is ignored and is not queued.
- Width rules: all address arithmetic is ADDR_W bits and wraps. A burst of 64 beats covers the whole RAM exactly once.

## Timing
- Reset (asynchronous, `rst_n=0`) takes effect immediately. State goes to IDLE, counters and FIFO clear, `inflight=0`. Output values:
  - `cmd_ready=1`
  - `wr_ready=0`
  - `rd_valid=0`
  - `rd_data=0`
  - `mem_we=0`
  - `mem_addr=0`
  - `mem_data=0`
  - `busy=0`
  - `done=0`
- Reset mid-burst aborts the burst. Writes already committed remain in the RAM. Read data in flight is discarded.
- Command accept at edge E: first `wr_ready` / first read issue occurs in the cycle after E.
- Write throughput is 1 beat/cycle. A beat's RAM write commits at the same edge as its handshake.
- Read latency: first `rd_valid` is 2 cycles after the first issue cycle (issue in cycle N, `mem_q` valid in N+1, FIFO push at end of N+1, `rd_valid` in N+2).
- With `rd_ready` held at 1, reads sustain 1 beat/cycle.
- `done` is registered: it is high for exactly one cycle, coincident with `cmd_ready` returning to 1.
- Back-to-back: a new command is accepted the cycle `done` is high, so there is one idle cycle between bursts.

## Test plan
Bench pairs the block with a behavioural single-port RAM (64×8, write on `we`, registered read address).
- Reset:
  - Stimulus: assert `rst_n=0` asynchronously between clock edges.
  - Required: all outputs take their reset values before the next edge; `cmd_ready=1`.
- Write with wrap:
  - Stimulus: cmd write, addr 0x3E, len 3, data 0x11/0x22/0x33/0x44 on consecutive cycles.
  - Required: `mem_we` high at 0x3E, 0x3F, 0x00, 0x01; `done` pulses the cycle after the 4th beat.
- Read, no stall:
  - Stimulus: cmd read, addr 0x3E, len 3, `rd_ready=1`.
  - Required: `rd_data` is 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; the first beat arrives 2 cycles after the first issue; then `done`.
- Read backpressure:
  - Stimulus: read len 7 with `rd_ready=0` for 5 cycles, then toggling.
  - Required: never more than 2 reads outstanding or buffered; all 8 values delivered in order.
- Write gaps:
  - Stimulus: write len 2 with `wr_valid` pattern 1,0,0,1,0,1.
  - Required: `mem_we` asserted only on the 3 valid cycles; RAM holds exactly 3 words; `cmd_valid` pulsed during the burst is ignored.
- Reset mid-read:
  - Stimulus: assert `rst_n=0` during the 2nd beat of a len 7 read.
  - Required: `rd_valid` drops to 0 immediately; after release, a new write command is accepted normally.
